// File: rtl/iq_serializer.sv
// iq_serializer: captures a parallel frame of N_CH signed I/Q word pairs and
// replays it as one word per clock (I0, Q0, I1, Q1, ...), followed by a
// one-cycle gap. A one-deep pending buffer absorbs a frame that arrives while
// another frame is still being sent. If a further frame arrives while the
// buffer is full, that frame is dropped and the sticky overflow flag is set.
// Optional build macro IQ_SERIALIZER_OVF_COUNT_EN adds a 16-bit saturating
// dropped-frame counter on output ovf_count.
module iq_serializer #(
   parameter int DW   = 21,
   parameter int N_CH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               strobe_in,
   input  logic [N_CH*DW-1:0] i_in,
   input  logic [N_CH*DW-1:0] q_in,
   output logic [DW-1:0]      stream_out,
   output logic               strobe_out,
   output logic               busy,
   output logic               overflow,
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
   output logic [15:0]        ovf_count,
`endif
   input  logic               overflow_clr
);

   localparam int N_W = 2 * N_CH;
   localparam int CW  = (N_W > 1) ? $clog2(N_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic                pend_full;
   logic [N_CH*DW-1:0]  snap_i;
   logic [N_CH*DW-1:0]  snap_q;
   logic [N_CH*DW-1:0]  pend_i;
   logic [N_CH*DW-1:0]  pend_q;

   logic                load_in;
   logic                load_pend;
   logic                store_pend;
   logic                drop;
   logic [CW-1:0]       cnt_nxt;

   // Returns word idx of a frame: even index selects I, odd selects Q.
   function automatic logic [DW-1:0] pick_word(input logic [N_CH*DW-1:0] iv,
                                               input logic [N_CH*DW-1:0] qv,
                                               input logic [CW-1:0]      idx);
      int k;
      k = int'(idx >> 1);
      return idx[0] ? qv[k*DW +: DW] : iv[k*DW +: DW];
   endfunction

   // A strobe in GAP with an empty pending buffer is passed straight through
   // to the snapshot, which is the same as storing it and loading it at once.
   assign load_in    = strobe_in && ((state == IDLE) || (state == GAP && !pend_full));
   assign load_pend  = (state == GAP) && pend_full;
   assign store_pend = strobe_in && (((state == SHIFT) && !pend_full) || load_pend);
   assign drop       = strobe_in && (state == SHIFT) && pend_full;
   assign cnt_nxt    = cnt + CW'(1);
   assign busy       = (state != IDLE) || pend_full;

   // Control FSM with registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         stream_out <= '0;
         strobe_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_in) begin
                  state      <= SHIFT;
                  cnt        <= '0;
                  strobe_out <= 1'b1;
                  stream_out <= i_in[DW-1:0];
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  state      <= GAP;
                  cnt        <= '0;
                  strobe_out <= 1'b0;
                  stream_out <= '0;
               end else begin
                  cnt        <= cnt_nxt;
                  stream_out <= pick_word(snap_i, snap_q, cnt_nxt);
               end
            end
            GAP: begin
               cnt <= '0;
               if (load_pend) begin
                  state      <= SHIFT;
                  strobe_out <= 1'b1;
                  stream_out <= pend_i[DW-1:0];
               end else if (load_in) begin
                  state      <= SHIFT;
                  strobe_out <= 1'b1;
                  stream_out <= i_in[DW-1:0];
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               strobe_out <= 1'b0;
               stream_out <= '0;
            end
         endcase
      end
   end

   // Pending-buffer occupancy and sticky overflow; a new drop beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (store_pend)
            pend_full <= 1'b1;
         else if (load_pend)
            pend_full <= 1'b0;

         if (drop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

   // Frame data registers; only control state needs reset.
   always_ff @(posedge clk) begin
      if (load_in) begin
         snap_i <= i_in;
         snap_q <= q_in;
      end else if (load_pend) begin
         snap_i <= pend_i;
         snap_q <= pend_q;
      end
      if (store_pend) begin
         pend_i <= i_in;
         pend_q <= q_in;
      end
   end

`ifdef IQ_SERIALIZER_OVF_COUNT_EN
   // Saturating drop counter; a clear on the same cycle as a drop leaves one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_count <= '0;
      else if (overflow_clr)
         ovf_count <= drop ? 16'd1 : 16'd0;
      else if (drop && (ovf_count != 16'hFFFF))
         ovf_count <= ovf_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_iq_serializer.sv
// Testbench for iq_serializer. It uses directed frames and a frame-level
// timeline model. Build with IQ_SERIALIZER_OVF_COUNT_EN to include ovf_count.
module tb_iq_serializer;

   localparam int DW   = 21;
   localparam int N_CH = 4;
   localparam int NW   = 2 * N_CH;
   localparam int RING = 1024;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               strobe_in = 1'b0;
   logic               overflow_clr = 1'b0;
   logic [N_CH*DW-1:0] i_in = '0;
   logic [N_CH*DW-1:0] q_in = '0;
   logic [DW-1:0]      stream_out;
   logic               strobe_out;
   logic               busy;
   logic               overflow;
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
   logic [15:0]        ovf_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model state: expected output timeline indexed by cycle number.
   logic              exp_strb [RING];
   logic [DW-1:0]     exp_word [RING];
   int                last_start = 0;
   bit                last_valid = 1'b0;
   bit                ovf_m = 1'b0;
   int                ovfc_m = 0;

   iq_serializer #(.DW(DW), .N_CH(N_CH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .strobe_in    (strobe_in),
      .i_in         (i_in),
      .q_in         (q_in),
      .stream_out   (stream_out),
      .strobe_out   (strobe_out),
      .busy         (busy),
      .overflow     (overflow),
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
      .ovf_count    (ovf_count),
`endif
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   function automatic int sx(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
      end
   endtask

   // Frame-level model. A frame accepted at edge e starts at e+1, or two
   // cycles after the previous frame's last word, whichever is later. It is
   // dropped if the previously accepted frame has not started by e+1.
   task automatic model_step();
      int  e;
      int  s;
      bit  drop_m;
      e = cyc;
      exp_strb[e % RING] = 1'b0;
      if (!rst_n) begin
         for (int r = 0; r < RING; r++) begin
            exp_strb[r] = 1'b0;
            exp_word[r] = '0;
         end
         last_valid = 1'b0;
         ovf_m      = 1'b0;
         ovfc_m     = 0;
      end else begin
         drop_m = 1'b0;
         if (strobe_in) begin
            if (last_valid && (last_start > e + 1)) begin
               drop_m = 1'b1;
            end else begin
               s = e + 1;
               if (last_valid && (last_start + NW + 1 > s))
                  s = last_start + NW + 1;
               for (int j = 0; j < NW; j++) begin
                  exp_strb[(s + j) % RING] = 1'b1;
                  exp_word[(s + j) % RING] = (j % 2 == 1) ? q_in[(j/2)*DW +: DW]
                                                          : i_in[(j/2)*DW +: DW];
               end
               last_start = s;
               last_valid = 1'b1;
            end
         end
         if (drop_m)
            ovf_m = 1'b1;
         else if (overflow_clr)
            ovf_m = 1'b0;
         if (overflow_clr)
            ovfc_m = drop_m ? 1 : 0;
         else if (drop_m && ovfc_m < 65535)
            ovfc_m++;
      end
      cyc++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      int  idx;
      bit  es;
      forever begin
         @(negedge clk);
         idx = cyc % RING;
         if (!rst_n) begin
            chk("rst_strobe_out", int'(strobe_out), 0);
            chk("rst_stream_out", sx(stream_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_overflow", int'(overflow), 0);
         end else begin
            es = exp_strb[idx];
            chk("strobe_out", int'(strobe_out), int'(es));
            chk("stream_out", sx(stream_out), es ? sx(exp_word[idx]) : 0);
            chk("busy", int'(busy), int'(last_valid && (cyc <= last_start + NW)));
            chk("overflow", int'(overflow), int'(ovf_m));
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
            chk("ovf_count", int'(ovf_count), ovfc_m);
`endif
         end
      end
   end

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_frame(input int ib);
      for (int k = 0; k < N_CH; k++) begin
         i_in[k*DW +: DW] = DW'(ib + k);
         q_in[k*DW +: DW] = DW'(-(ib + k));
      end
   endtask

   task automatic frame(input int e, input int ib);
      wait_cyc(e);
      set_frame(ib);
      strobe_in = 1'b1;
      wait_cyc(e + 1);
      strobe_in = 1'b0;
   endtask

   task automatic chkw(input string name, input int c, input int want);
      wait_cyc(c);
      chk(name, sx(stream_out), want);
   endtask

   initial begin
      int b;
      int gaps [10] = '{1, 3, 9, 10, 2, 2, 2, 8, 11, 1};

      // Reset state
      wait_cyc(3);
      chk("lit_reset_strobe", int'(strobe_out), 0);
      chk("lit_reset_stream", sx(stream_out), 0);
      chk("lit_reset_busy", int'(busy), 0);
      chk("lit_reset_ovf", int'(overflow), 0);
      rst_n = 1'b1;

      // Single frame
      b = cyc;
      frame(b + 10, 100);
      chkw("lit_single_w0", b + 11, 100);
      chkw("lit_single_w1", b + 12, -100);
      chkw("lit_single_w2", b + 13, 101);
      chkw("lit_single_w7", b + 18, -103);
      wait_cyc(b + 19);
      chk("lit_single_gap", int'(strobe_out), 0);
      wait_cyc(b + 30);

      // Back-to-back frames
      b = cyc;
      frame(b + 10, 100);
      frame(b + 12, 200);
      wait_cyc(b + 19);
      chk("lit_b2b_gap", int'(strobe_out), 0);
      chkw("lit_b2b_second_w0", b + 20, 200);
      chkw("lit_b2b_second_w7", b + 27, -203);
      wait_cyc(b + 30);
      chk("lit_b2b_ovf", int'(overflow), 0);

      // Overflow, then clear
      b = cyc;
      frame(b + 10, 100);
      frame(b + 12, 200);
      frame(b + 14, 300);
      wait_cyc(b + 16);
      chk("lit_ovf_set", int'(overflow), 1);
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
      chk("lit_ovf_count1", int'(ovf_count), 1);
`endif
      chkw("lit_ovf_second_w0", b + 20, 200);
      wait_cyc(b + 30);
      overflow_clr = 1'b1;
      wait_cyc(b + 31);
      overflow_clr = 1'b0;
      chk("lit_ovf_cleared", int'(overflow), 0);

      // Clear coinciding with a drop: set wins
      b = cyc;
      frame(b + 10, 100);
      frame(b + 12, 200);
      wait_cyc(b + 14);
      set_frame(350);
      strobe_in    = 1'b1;
      overflow_clr = 1'b1;
      wait_cyc(b + 15);
      strobe_in    = 1'b0;
      overflow_clr = 1'b0;
      chk("lit_set_wins", int'(overflow), 1);
`ifdef IQ_SERIALIZER_OVF_COUNT_EN
      chk("lit_set_wins_count", int'(ovf_count), 1);
`endif
      wait_cyc(b + 30);
      overflow_clr = 1'b1;
      wait_cyc(b + 31);
      overflow_clr = 1'b0;

      // Input change while a frame is in flight
      b = cyc;
      frame(b + 10, 100);
      wait_cyc(b + 12);
      set_frame(900);
      chkw("lit_inflight_w2", b + 13, 101);
      chkw("lit_inflight_w6", b + 17, 103);
      wait_cyc(b + 30);

      // Reset in the middle of a frame
      b = cyc;
      frame(b + 10, 400);
      wait_cyc(b + 14);
      #1;
      rst_n = 1'b0;
      #1;
      chk("lit_midrst_strobe", int'(strobe_out), 0);
      chk("lit_midrst_stream", sx(stream_out), 0);
      wait_cyc(b + 16);
      rst_n = 1'b1;
      frame(b + 18, 500);
      chkw("lit_postrst_w0", b + 19, 500);
      chkw("lit_postrst_w7", b + 26, -503);
      wait_cyc(b + 27);
      chk("lit_postrst_gap", int'(strobe_out), 0);
      wait_cyc(b + 35);

      // Strobe during the gap with an empty pending buffer
      b = cyc;
      frame(b + 10, 600);
      frame(b + 19, 700);
      chkw("lit_gapstrobe_w0", b + 20, 700);
      wait_cyc(b + 35);

      // Strobe on the same cycle as the pending load
      b = cyc;
      frame(b + 10, 100);
      frame(b + 12, 200);
      frame(b + 19, 300);
      chkw("lit_gapload_third_w0", b + 29, 300);
      wait_cyc(b + 30);
      chk("lit_gapload_ovf", int'(overflow), 0);
      wait_cyc(b + 45);

      // Irregular strobe spacing; the model tracks accepts and drops
      b = cyc + 2;
      for (int n = 0; n < 10; n++) begin
         frame(b, 1000 + 37 * n);
         b = b + gaps[n];
      end
      wait_cyc(b + 30);
      overflow_clr = 1'b1;
      wait_cyc(b + 31);
      overflow_clr = 1'b0;
      wait_cyc(b + 35);

`ifdef IQ_SERIALIZER_OVF_COUNT_EN
      // Saturation: a continuously held strobe drops 8 frames every 9 cycles
      b = cyc;
      set_frame(50);
      strobe_in = 1'b1;
      wait_cyc(b + 74000);
      strobe_in = 1'b0;
      wait_cyc(b + 74030);
      chk("lit_ovf_count_sat", int'(ovf_count), 65535);
`endif

      wait_cyc(cyc + 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/iq_serializer.md
IQ_SERIALIZER -- requirements
Module: iq_serializer

Interface
REQ-001 SHALL have parameter DW, default 21: width of each I or Q word.
REQ-002 SHALL have parameter N_CH, default 4: number of I/Q channel pairs per frame, 1..8.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port strobe_in, input, 1: parallel frame valid, one-cycle pulse.
REQ-006 SHALL have port i_in, input, N_CH*DW: packed signed I words; channel k at bits [k*DW +: DW].
REQ-007 SHALL have port q_in, input, N_CH*DW: packed signed Q words, same packing as i_in.
REQ-008 SHALL have port stream_out, output, DW: serialized word stream.
REQ-009 SHALL have port strobe_out, output, 1: high while stream_out carries a valid frame word.
REQ-010 SHALL have port busy, output, 1: high in SHIFT or GAP state, or while the pending buffer is full.
REQ-011 SHALL have port overflow, output, 1: sticky flag, a frame was dropped.
REQ-012 SHALL have port overflow_clr, input, 1: synchronous clear of overflow.

Function
REQ-013 SHALL emit each frame as 2*N_CH consecutive strobe_out cycles in the order I0, Q0, I1, Q1, ..., I(N_CH-1), Q(N_CH-1).
REQ-014 SHALL latch i_in/q_in into a snapshot register on the accepting strobe_in edge; later input changes SHALL NOT affect the frame in flight.
REQ-015 SHALL use the states IDLE, SHIFT and GAP.
REQ-016 IDLE + strobe_in: SHALL load the snapshot and enter SHIFT; I0 SHALL appear on stream_out with strobe_out=1 exactly one cycle after strobe_in (latency 1).
REQ-017 SHIFT: SHALL advance a word counter 0..2*N_CH-1 every cycle; at count 2*N_CH-1 SHALL enter GAP.
REQ-018 GAP: SHALL last exactly one cycle with strobe_out=0, so the receiver can delimit frames; then go to SHIFT if the pending buffer is full (loading it into the snapshot and emptying it), else to IDLE.
REQ-019 SHALL hold a one-deep pending buffer; strobe_in in SHIFT or GAP while pending is empty SHALL store the frame into pending.
REQ-020 strobe_in while pending is full SHALL drop the new frame, keep the pending frame and set overflow.
REQ-021 strobe_in on the same cycle as the GAP-to-SHIFT pending load SHALL be stored into the freshly emptied pending buffer, with no overflow.
REQ-022 overflow_clr and a new overflow event on the same cycle: overflow SHALL remain 1 (set wins).
REQ-023 stream_out SHALL be 0 whenever strobe_out=0.
REQ-024 stream_out and strobe_out SHALL be driven from registers; no combinational path from inputs.
REQ-025 Words SHALL pass unmodified; no arithmetic on data.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, word counter 0, pending empty, stream_out=0, strobe_out=0, busy=0, overflow=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release, the first strobe_in SHALL start a complete new frame at I0.

Configuration
REQ-028 With macro IQ_SERIALIZER_OVF_COUNT_EN defined, SHALL add output ovf_count, 16 bits: count of dropped frames, saturating at 16'hFFFF, reset to 0 by rst_n and cleared by overflow_clr (a drop on the same cycle yields 1).
REQ-029 Without IQ_SERIALIZER_OVF_COUNT_EN, port ovf_count and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single frame: DW=21, N_CH=4, I_k=100+k, Q_k=-(100+k), strobe_in at cycle 10 -> strobe_out high cycles 11..18 carrying 100,-100,101,-101,102,-102,103,-103; low at cycle 19.
REQ-031 Back-to-back: strobe_in at cycles 10 and 12 (second frame I_k=200+k) -> first frame 11..18, gap 19, second frame 20..27 starting with 200; overflow=0.
REQ-032 Overflow: strobe_in at cycles 10, 12 and 14 -> frames from cycles 10 and 12 emitted, cycle-14 frame dropped, overflow=1 (ovf_count=1 when enabled); overflow_clr pulse -> overflow=0.
REQ-033 Input change in flight: modify i_in at cycle 12 during a frame started at cycle 10 -> emitted words equal the values sampled at cycle 10.
REQ-034 Reset mid-frame: rst_n low at cycle 14 of a frame started at cycle 10 -> strobe_out=0 and stream_out=0 immediately; strobe_in two cycles after release -> full 8-word frame starting at I0.
REQ-035 Saturation (macro defined): force 65540 drop events -> ovf_count holds 16'hFFFF.
